spi_flash_reader: RTL and testbench
===================================

# spi_flash_reader

SPI flash read master: accepts a read request (24-bit address, 1–8 bytes), issues a standard READ (0x03) command in SPI mode 0, and returns the bytes on a 64-bit response port. It drives the SoC-level `spi_flash_clk`/`spi_flash_cs`/`spi_flash_mosi`/`spi_flash_miso` pins and is the initiator for the N25Qxxx-class flash used in simulation and on silicon. Its purpose is to fetch boot images and constant data from external flash.

## Interface
- `DIV`, default 2: SCK half-period in `clock` cycles; legal range ≥1.
- `clock`  in  1  sole clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  read request valid.
- `req_ready`  out  1  request accepted when `req_valid & req_ready`.
- `req_addr`  in  24  flash byte address.
- `req_len`  in  3  byte count minus 1 (0 → 1 byte, 7 → 8 bytes).
- `req_sel`  in  1  chip select index (0 → `spi_flash_cs[0]`, 1 → `spi_flash_cs[1]`).
- `rsp_valid`  out  1  response data valid.
- `rsp_ready`  in  1  response consumed when `rsp_valid & rsp_ready`.
- `rsp_data`  out  64  read bytes; first byte received in [7:0], unread bytes zero.
- `spi_flash_clk`  out  1  SCK; idle low.
- `spi_flash_cs`  out  2  active-low chip selects; idle 2'b11.
- `spi_flash_mosi`  out  1  serial data to flash.
- `spi_flash_miso`  in  1  serial data from flash.

## Operation
- States: IDLE, SHIFT, HOLD, RESP.
- IDLE: `req_ready`=1. On accept, latch addr/len/sel and load the 32-bit shift register {8'h03, addr}. Set the bit count N = 32 + 8·(len+1). Go to SHIFT.
- SHIFT: `spi_flash_cs[sel]`=0, other CS=1. Each bit lasts 2·DIV cycles: DIV cycles SCK low, then DIV cycles SCK high. MSB first.
  - MOSI is valid for the whole bit. It updates only on the cycle where SCK goes high→low, and is held 0 after the 32 command/address bits.
  - MISO is sampled on the clock edge that drives SCK low→high. Bits 0–31 are ignored (don't-care).
  - Data bits are shifted into the byte assembler MSB-first. Completed byte k is written to `rsp_data[8k+7:8k]`.
- After the high phase of bit N−1, SCK returns low and the FSM enters HOLD.
- HOLD: CS stays low and SCK low for DIV cycles, then CS returns to 2'b11 and the FSM enters RESP.
- RESP: `rsp_valid`=1 with `rsp_data` stable until `rsp_ready`. On handshake, go to IDLE. `rsp_data` is cleared to 0 at the next accept, not at handshake.
- `req_ready`=0 in SHIFT, HOLD and RESP; there is exactly one outstanding request.
- The bit counter is 7 bits (max N = 96); the DIV counter is sized to clog2(DIV)+1.
- Address wrap-around is the flash's concern; the address is sent as given.
- Reset (any state, including mid-SHIFT): the next cycle shows IDLE, `spi_flash_cs`=2'b11, `spi_flash_clk`=0, `spi_flash_mosi`=0, `rsp_valid`=0, `rsp_data`=0, `req_ready`=1. An aborted request produces no response.

## Timing
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_data`=0, `spi_flash_cs`=2'b11, `spi_flash_clk`=0, `spi_flash_mosi`=0.
- Accept at cycle T gives:
  - CS low and MOSI = bit 7 of 0x03 at T+1.
  - First SCK rise at T+1+DIV.
  - CS high and `rsp_valid`=1 at T+1+2·DIV·N+DIV.
- Latency for DIV=2, len=7: N=96, `rsp_valid` at T+387. For DIV=1, len=0: N=40, `rsp_valid` at T+82.
- All pin outputs are registered; there is no combinational path from `spi_flash_miso` or `rsp_ready` to any pin.
- Minimum CS-high time between transactions is 2 cycles (RESP handshake cycle plus IDLE accept cycle).
- `req_valid` asserted in the RESP handshake cycle is not accepted until the following IDLE cycle.

## Test plan
- DIV=2, flash holds 0x11,0x22,…,0x88 at 0x000100. Read addr 0x000100, len=7, `rsp_ready`=1 → MOSI stream 0x03,0x00,0x01,0x00; 96 SCK rises; `rsp_valid` at T+387; `rsp_data`=0x8877665544332211; CS[0] toggles, CS[1] stays 1.
- DIV=1, len=0, same address → `rsp_data`=0x0000000000000011; `rsp_valid` at T+82; SCK period 2 cycles, 40 pulses.
- Hold `rsp_ready`=0 for 20 cycles after `rsp_valid` → `rsp_valid` and `rsp_data` stable, `req_ready`=0, CS=2'b11, SCK=0 throughout; handshake then returns to IDLE. A back-to-back request gives CS high for exactly 2 cycles.
- `req_sel`=1, addr 0xFFFFFC, len=3 → only `spi_flash_cs[1]` asserts; address bytes 0xFF,0xFF,0xFC appear on MOSI; `rsp_data[63:32]`=0.
- Assert `reset` for 1 cycle at bit 40 of a len=7 read → next cycle CS=2'b11, SCK=0, `req_ready`=1, no `rsp_valid` ever appears. A new read then completes normally with correct data.
- MOSI/MISO protocol checker on all tests: MOSI never changes while SCK=1; SCK never toggles while both CS are high.

Source files
------------

// File: rtl/spi_flash_reader.sv
// spi_flash_reader: SPI mode-0 READ (0x03) master returning 1-8 bytes on a 64-bit response
module spi_flash_reader #(
    parameter int DIV = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    input  logic [2:0]  req_len,
    input  logic        req_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_data,
    output logic        spi_flash_clk,
    output logic [1:0]  spi_flash_cs,
    output logic        spi_flash_mosi,
    input  logic        spi_flash_miso
);
    localparam int CW = $clog2(DIV) + 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
    localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, HOLD = 2'd2, RESP = 2'd3;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0]    bit_q, bit_d, last_q, last_d;
    logic [31:0]   sr_q, sr_d;
    logic [63:0]   data_q, data_d;
    logic [1:0]    cs_q, cs_d;
    logic          sck_q, sck_d;
    logic [5:0]    dbit;
    logic          phase_end;
    assign dbit      = bit_q[5:0] - 6'd32;
    assign phase_end = cnt_q == DIV_LAST;
    assign req_ready      = state_q == IDLE;
    assign rsp_valid      = state_q == RESP;
    assign rsp_data       = data_q;
    assign spi_flash_clk  = sck_q;
    assign spi_flash_cs   = cs_q;
    assign spi_flash_mosi = sr_q[31];
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        last_d  = last_q;
        sr_d    = sr_q;
        data_d  = data_q;
        cs_d    = cs_q;
        sck_d   = sck_q;
        case (state_q)
            IDLE: if (req_valid) begin
                state_d = SHIFT;
                cnt_d   = '0;
                bit_d   = '0;
                last_d  = 7'd39 + {1'b0, req_len, 3'b000};
                sr_d    = {8'h03, req_addr};
                data_d  = '0;
                cs_d    = req_sel ? 2'b01 : 2'b10;
                sck_d   = 1'b0;
            end
            SHIFT: begin
                cnt_d = phase_end ? '0 : cnt_q + 1'b1;
                if (phase_end && !sck_q) begin
                    sck_d = 1'b1;
                    // data bit d lands in byte d/8, MSB first within the byte
                    if (bit_q >= 7'd32) data_d[{dbit[5:3], ~dbit[2:0]}] = spi_flash_miso;
                end else if (phase_end) begin
                    sck_d = 1'b0;
                    sr_d  = {sr_q[30:0], 1'b0};
                    bit_d = bit_q + 7'd1;
                    if (bit_q == last_q) state_d = HOLD;
                end
            end
            HOLD: begin
                cnt_d = phase_end ? '0 : cnt_q + 1'b1;
                if (phase_end) begin
                    cs_d    = 2'b11;
                    state_d = RESP;
                end
            end
            default: if (rsp_ready) state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            last_q  <= '0;
            sr_q    <= '0;
            data_q  <= '0;
            cs_q    <= 2'b11;
            sck_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            last_q  <= last_d;
            sr_q    <= sr_d;
            data_q  <= data_d;
            cs_q    <= cs_d;
            sck_q   <= sck_d;
        end
    end
endmodule

// File: tb/tb_spi_flash_reader.sv
// tb_spi_flash_reader: two readers (DIV=2 as u0, DIV=1 as u1) against a flash model and a timing model
module tb_spi_flash_reader;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid [2];
    logic        req_ready [2];
    logic [23:0] req_addr  [2];
    logic [2:0]  req_len   [2];
    logic        req_sel   [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [63:0] rsp_data  [2];
    logic        sck       [2];
    logic [1:0]  cs        [2];
    logic        mosi      [2];
    logic        miso      [2];
    int          frises    [2];
    logic [31:0] fcmd      [2];
    int n_cmp = 0;
    int n_bad = 0;
    always #5 clock = ~clock;
    for (genvar g = 0; g < 2; g++) begin : gi
        spi_flash_reader #(.DIV(2 - g)) dut (
            .clock(clock), .reset(reset),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_addr(req_addr[g]),
            .req_len(req_len[g]), .req_sel(req_sel[g]),
            .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]), .rsp_data(rsp_data[g]),
            .spi_flash_clk(sck[g]), .spi_flash_cs(cs[g]),
            .spi_flash_mosi(mosi[g]), .spi_flash_miso(miso[g])
        );
    end
    function automatic logic [7:0] mem(logic [23:0] a);
        return (a >= 24'h100 && a < 24'h108) ? 8'h11 * 8'(a - 24'hFF) : a[7:0] ^ 8'h5A;
    endfunction
    function automatic int dv(int k);
        return 2 - k;
    endfunction
    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask
    // flash: shifts in command/address on SCK rise, presents data on SCK fall
    initial begin
        logic ps [2];
        logic [1:0] pc [2];
        logic [7:0] b;
        int j;
        for (int k = 0; k < 2; k++) begin
            miso[k] = 1'b0; frises[k] = 0; fcmd[k] = '0; ps[k] = 1'b0; pc[k] = 2'b11;
        end
        forever begin
            @(negedge clock);
            for (int k = 0; k < 2; k++) begin
                if (cs[k] != 2'b11 && pc[k] == 2'b11) begin
                    frises[k] = 0;
                    fcmd[k] = '0;
                end
                if (cs[k] != 2'b11 && sck[k] && !ps[k]) begin
                    if (frises[k] < 32) fcmd[k] = {fcmd[k][30:0], mosi[k]};
                    frises[k]++;
                end
                if (cs[k] != 2'b11 && !sck[k] && ps[k] && frises[k] >= 32) begin
                    j = frises[k] - 32;
                    b = mem(fcmd[k][23:0] + 24'(j / 8));
                    miso[k] = b[7 - j % 8];
                end
                ps[k] = sck[k];
                pc[k] = cs[k];
            end
        end
    end
    // reference model: per-cycle pin/handshake expectations from the transaction timing rules
    initial begin
        int cyc;
        bit busy [2];
        int t1 [2], nb [2];
        logic [31:0] cw [2];
        logic msel [2];
        logic [63:0] xd [2];
        logic ps [2], pm [2];
        logic [1:0] pc [2];
        cyc = 0;
        for (int k = 0; k < 2; k++) begin
            busy[k] = 0; t1[k] = 0; nb[k] = 0; cw[k] = '0; msel[k] = 0; xd[k] = '0;
            ps[k] = 0; pm[k] = 0; pc[k] = 2'b11;
        end
        forever begin
            @(posedge clock);
            for (int k = 0; k < 2; k++) begin
                if (reset) begin
                    busy[k] = 0;
                    xd[k] = '0;
                end else if (!busy[k]) begin
                    if (req_valid[k]) begin
                        busy[k] = 1;
                        t1[k] = cyc + 1;
                        nb[k] = 40 + 8 * int'(req_len[k]);
                        cw[k] = {8'h03, req_addr[k]};
                        msel[k] = req_sel[k];
                        xd[k] = '0;
                        for (int i = 0; i <= int'(req_len[k]); i++) xd[k][8*i +: 8] = mem(req_addr[k] + 24'(i));
                    end
                end else if (cyc - t1[k] >= 2 * dv(k) * nb[k] + dv(k) && rsp_ready[k]) busy[k] = 0;
            end
            cyc++;
            @(negedge clock);
            for (int k = 0; k < 2; k++) begin
                int d, o, tot;
                logic sh, hd, rs, esck, emosi;
                logic [1:0] ecs;
                d = dv(k);
                o = cyc - t1[k];
                tot = 2 * d * nb[k];
                sh = busy[k] && o < tot;
                hd = busy[k] && o >= tot && o < tot + d;
                rs = busy[k] && o >= tot + d;
                ecs = (sh || hd) ? (msel[k] ? 2'b01 : 2'b10) : 2'b11;
                esck = sh && (o % (2 * d)) >= d;
                emosi = (sh && (o / (2 * d)) < 32) ? cw[k][31 - o / (2 * d)] : 1'b0;
                check($sformatf("u%0d req_ready", k), 64'(req_ready[k]), 64'(!busy[k]));
                check($sformatf("u%0d rsp_valid", k), 64'(rsp_valid[k]), 64'(rs));
                check($sformatf("u%0d cs", k), 64'(cs[k]), 64'(ecs));
                check($sformatf("u%0d sck", k), 64'(sck[k]), 64'(esck));
                check($sformatf("u%0d mosi", k), 64'(mosi[k]), 64'(emosi));
                if (!busy[k] || rs) check($sformatf("u%0d rsp_data", k), rsp_data[k], xd[k]);
                if (ps[k] && sck[k]) check($sformatf("u%0d mosi moved while sck high", k), 64'(mosi[k]), 64'(pm[k]));
                if (pc[k] == 2'b11 && cs[k] == 2'b11) check($sformatf("u%0d sck moved while cs idle", k), 64'(sck[k]), 64'(ps[k]));
                ps[k] = sck[k];
                pm[k] = mosi[k];
                pc[k] = cs[k];
            end
        end
    end
    task automatic start(int k, logic [23:0] a, logic [2:0] l, logic s);
        req_addr[k] = a;
        req_len[k] = l;
        req_sel[k] = s;
        req_valid[k] = 1'b1;
        @(negedge clock);
        req_valid[k] = 1'b0;
    endtask
    task automatic wait_rsp(int k, int lat_exp, logic [63:0] d_exp, string nm);
        int lat = 1;
        while (!rsp_valid[k] && lat < 600) begin
            @(negedge clock);
            lat++;
        end
        check({nm, " latency"}, 64'(lat), 64'(lat_exp));
        check({nm, " data"}, rsp_data[k], d_exp);
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
    initial begin
        int seen;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0; req_addr[k] = '0; req_len[k] = '0; req_sel[k] = 1'b0; rsp_ready[k] = 1'b1;
        end
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("u%0d reset req_ready", k), 64'(req_ready[k]), 64'd1);
            check($sformatf("u%0d reset cs", k), 64'(cs[k]), 64'h3);
            check($sformatf("u%0d reset rsp_data", k), rsp_data[k], 64'd0);
        end
        start(0, 24'h000100, 3'd7, 1'b0);
        wait_rsp(0, 387, 64'h8877665544332211, "div2 len7");
        @(negedge clock);
        check("div2 len7 cmd", 64'(fcmd[0]), 64'h03000100);
        check("div2 len7 sck rises", 64'(frises[0]), 64'd96);
        start(1, 24'h000100, 3'd0, 1'b0);
        wait_rsp(1, 82, 64'h0000000000000011, "div1 len0");
        @(negedge clock);
        check("div1 len0 cmd", 64'(fcmd[1]), 64'h03000100);
        check("div1 len0 sck rises", 64'(frises[1]), 64'd40);
        rsp_ready[0] = 1'b0;
        start(0, 24'h000100, 3'd7, 1'b0);
        wait_rsp(0, 387, 64'h8877665544332211, "stall len7");
        repeat (20) begin
            @(negedge clock);
            check("stall rsp_valid", 64'(rsp_valid[0]), 64'd1);
            check("stall req_ready", 64'(req_ready[0]), 64'd0);
            check("stall cs", 64'(cs[0]), 64'h3);
            check("stall sck", 64'(sck[0]), 64'd0);
        end
        check("stall data", rsp_data[0], 64'h8877665544332211);
        rsp_ready[0] = 1'b1;
        @(negedge clock);
        check("b2b gap cs", 64'(cs[0]), 64'h3);
        start(0, 24'hFFFFFC, 3'd3, 1'b1);
        check("sel1 cs", 64'(cs[0]), 64'h1);
        wait_rsp(0, 259, 64'h00000000A5A4A7A6, "sel1 len3");
        @(negedge clock);
        check("sel1 cmd", 64'(fcmd[0]), 64'h03FFFFFC);
        check("sel1 sck rises", 64'(frises[0]), 64'd64);
        start(0, 24'h000100, 3'd7, 1'b0);
        repeat (160) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort cs", 64'(cs[0]), 64'h3);
        check("abort sck", 64'(sck[0]), 64'd0);
        check("abort req_ready", 64'(req_ready[0]), 64'd1);
        check("abort rsp_data", rsp_data[0], 64'd0);
        seen = 0;
        repeat (500) begin
            @(negedge clock);
            if (rsp_valid[0]) seen++;
        end
        check("abort no response", 64'(seen), 64'd0);
        start(0, 24'h000104, 3'd1, 1'b0);
        wait_rsp(0, 195, 64'h0000000000006655, "after abort len1");
        @(negedge clock);
        check("after abort sck rises", 64'(frises[0]), 64'd48);
        repeat (5) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
